// File: rtl/noc_pkg.sv
// Shared flit definitions for the NoC ingress path.
// Flit layout: [16] valid, [15:12] dest, [11:8] src, [7:0] data; all-zero is idle.
package noc_pkg;

  localparam int unsigned FLIT_W    = 17;
  localparam int unsigned VALID_BIT = 16;
  localparam int unsigned DEST_HI   = 15;
  localparam int unsigned DEST_LO   = 12;
  localparam int unsigned SRC_HI    = 11;
  localparam int unsigned SRC_LO    = 8;
  localparam int unsigned DATA_HI   = 7;
  localparam int unsigned DATA_LO   = 0;

  // Adapter splits a 32-bit word into four byte flits.
  localparam int unsigned PKT_LEN_DEFAULT = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic logic [3:0] flit_src(input flit_t f);
    return f[SRC_HI:SRC_LO];
  endfunction

  function automatic flit_t make_flit(input logic [3:0] dest, input logic [3:0] src,
                                      input logic [7:0] data);
    flit_t f;
    f                  = '0;
    f[VALID_BIT]       = 1'b1;
    f[DEST_HI:DEST_LO] = dest;
    f[SRC_HI:SRC_LO]   = src;
    f[DATA_HI:DATA_LO] = data;
    return f;
  endfunction

endpackage

// File: rtl/noc_flit_rx_buffer_if.sv
// Adapter-facing and crossbar-facing signals of the flit RX buffer.
//   f_a        : flit from the adapter          stall      : back-pressure to adapter
//   to_x       : flit at FIFO head              to_x_valid : to_x holds a flit
//   to_x_head  : first flit of a packet         to_x_tail  : last flit of a packet
//   x_ready    : crossbar accepts to_x          drop_cnt   : saturating overflow count
//   err_src    : sticky mixed-source flag
// slave modport is the buffer itself; master is its environment.
interface noc_flit_rx_buffer_if
  import noc_pkg::*;
#(
  parameter int unsigned DROP_W = 8
);

  flit_t             f_a;
  logic              stall;
  flit_t             to_x;
  logic              to_x_valid;
  logic              to_x_head;
  logic              to_x_tail;
  logic              x_ready;
  logic [DROP_W-1:0] drop_cnt;
  logic              err_src;

  modport slave (
    input  f_a, x_ready,
    output stall, to_x, to_x_valid, to_x_head, to_x_tail, drop_cnt, err_src
  );

  modport master (
    output f_a, x_ready,
    input  stall, to_x, to_x_valid, to_x_head, to_x_tail, drop_cnt, err_src
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with asynchronous active-high reset.
//   push/wdata : write an entry (caller guarantees not full unless popping)
//   pop        : retire the head entry (caller guarantees not empty)
//   rdata      : entry at the read pointer (raw, not masked when empty)
//   count      : occupancy 0..DEPTH; full/empty decoded from it
// Storage is not reset.
module noc_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 17,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/noc_flit_rx_buffer.sv
// Router ingress stage: buffers adapter flits, frames them into PKT_LEN-flit packets
// and offers them to the crossbar over valid/ready.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of noc_flit_rx_buffer_if (flit in, stall out, crossbar
//              flit/valid/head/tail out, x_ready in, drop_cnt and err_src out)
module noc_flit_rx_buffer
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PKT_LEN = PKT_LEN_DEFAULT,
  parameter int unsigned DROP_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_flit_rx_buffer_if.slave  bus
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  flit_t             head_flit;
  logic [CntW-1:0]   count, count_next;
  logic              full, empty;
  logic              in_valid, push, pop, drop;

  logic [BeatW-1:0]  beat_q;
  logic [3:0]        head_src_q;
  logic              stall_q;
  logic              err_src_q;
  logic [DROP_W-1:0] drop_cnt_q;

  assign in_valid = bus.f_a[VALID_BIT];
  assign pop      = !empty && bus.x_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = in_valid && (!full || pop);
  assign drop     = in_valid && full && !pop;

  noc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.f_a),
    .rdata (head_flit),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q     <= '0;
      head_src_q <= '0;
      stall_q    <= 1'b0;
      err_src_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      // Raised one entry early: the adapter needs a cycle to see it.
      stall_q <= (count_next >= CntW'(DEPTH - 1));

      if (drop && (drop_cnt_q != {DROP_W{1'b1}})) drop_cnt_q <= drop_cnt_q + 1'b1;

      // Framing follows popped flits only; drops never shift packet boundaries.
      if (pop) begin
        if (beat_q == BeatW'(PKT_LEN - 1)) beat_q <= '0;
        else                               beat_q <= beat_q + 1'b1;

        if (beat_q == '0)                           head_src_q <= flit_src(head_flit);
        else if (flit_src(head_flit) != head_src_q) err_src_q  <= 1'b1;
      end
    end
  end

  assign bus.to_x       = empty ? '0 : head_flit;
  assign bus.to_x_valid = !empty;
  assign bus.to_x_head  = !empty && (beat_q == '0);
  assign bus.to_x_tail  = !empty && (beat_q == BeatW'(PKT_LEN - 1));
  assign bus.stall      = stall_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.err_src    = err_src_q;

endmodule

// File: tb/tb_noc_flit_rx_buffer.sv
// Self-checking bench for noc_flit_rx_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the buffer.
module tb_noc_flit_rx_buffer;
  import noc_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned PKT_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_flit_rx_buffer_if #(.DROP_W(8)) bus ();
  noc_flit_rx_buffer_if #(.DROP_W(2)) bus2 ();

  noc_flit_rx_buffer #(.DEPTH(DEPTH), .PKT_LEN(PKT_LEN), .DROP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  noc_flit_rx_buffer #(.DEPTH(DEPTH), .PKT_LEN(PKT_LEN), .DROP_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the buffered flits in order, packet position from total pops.
  flit_t      mq[$];
  int         popped;
  int         dropped;
  bit         m_err;
  logic [3:0] m_hsrc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    popped  = 0;
    dropped = 0;
    m_err   = 1'b0;
    m_hsrc  = '0;
  endtask

  task automatic model_edge(input flit_t f, input logic rdy);
    int    sz;
    bit    do_pop;
    flit_t h;
    sz     = mq.size();
    do_pop = (sz != 0) && rdy;
    if (do_pop) begin
      h = mq.pop_front();
      if (popped % PKT_LEN == 0) m_hsrc = h[SRC_HI:SRC_LO];
      else if (h[SRC_HI:SRC_LO] != m_hsrc) m_err = 1'b1;
      popped++;
    end
    if (f[VALID_BIT]) begin
      if (sz < DEPTH || do_pop) mq.push_back(f);
      else dropped++;
    end
  endtask

  task automatic check_outputs();
    int sz;
    int pos;
    sz  = mq.size();
    pos = popped % PKT_LEN;
    check_eq("to_x", 32'(bus.to_x), (sz != 0) ? 32'(mq[0]) : 32'd0);
    check_eq("to_x_valid", 32'(bus.to_x_valid), 32'(sz != 0));
    check_eq("to_x_head", 32'(bus.to_x_head), 32'((sz != 0) && (pos == 0)));
    check_eq("to_x_tail", 32'(bus.to_x_tail), 32'((sz != 0) && (pos == PKT_LEN - 1)));
    check_eq("stall", 32'(bus.stall), 32'(sz >= DEPTH - 1));
    check_eq("drop_cnt", 32'(bus.drop_cnt), (dropped > 255) ? 32'd255 : 32'(dropped));
    check_eq("err_src", 32'(bus.err_src), 32'(m_err));
  endtask

  // Drive inputs after an edge, clock once, then compare 1 time unit after the edge.
  task automatic step(input flit_t f, input logic rdy);
    bus.f_a     = f;
    bus.x_ready = rdy;
    @(posedge clk);
    model_edge(f, rdy);
    #1;
    check_outputs();
  endtask

  initial begin
    int    fill;
    int    rdy_pct;
    flit_t f;
    logic  [1:0] sat_exp [5];

    bus.f_a     = '0;
    bus.x_ready = 1'b0;
    bus2.f_a    = '0;
    bus2.x_ready = 1'b0;
    model_reset();

    // Reset state
    #3;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Single packet, crossbar always ready
    step(17'h10A11, 1'b1);
    check_eq("pkt_first_head", 32'(bus.to_x_head), 32'd1);
    step(17'h10A22, 1'b1);
    step(17'h10A33, 1'b1);
    step(17'h10A44, 1'b1);
    check_eq("pkt_last_tail", 32'(bus.to_x_tail), 32'd1);
    for (int i = 0; i < 2; i++) step('0, 1'b1);

    // Back-pressure: 10 flits into a stalled crossbar
    for (int i = 0; i < 10; i++) begin
      step(make_flit(4'h1, 4'h3, 8'(i)), 1'b0);
      if (i == 5) check_eq("stall_before_7", 32'(bus.stall), 32'd0);
      if (i == 6) check_eq("stall_at_7", 32'(bus.stall), 32'd1);
    end
    check_eq("bp_drop_cnt", 32'(bus.drop_cnt), 32'd2);
    check_eq("bp_head_data", 32'(bus.to_x), 32'(make_flit(4'h1, 4'h3, 8'd0)));

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 5; i++) step(make_flit(4'h2, 4'h3, 8'(8'h40 + i)), 1'b1);
    check_eq("full_pp_drop", 32'(bus.drop_cnt), 32'd2);
    check_eq("full_pp_stall", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 16 && mq.size() != 0; i++) step('0, 1'b1);
    check_eq("drained", 32'(bus.to_x_valid), 32'd0);

    // Realign to a packet boundary with same-source filler flits
    fill = (PKT_LEN - popped % PKT_LEN) % PKT_LEN;
    for (int i = 0; i < fill; i++) step(make_flit(4'h2, 4'h3, 8'hF0), 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b1);

    // Source mismatch inside one packet, then clean packets
    step(make_flit(4'h4, 4'hA, 8'h01), 1'b1);
    step(make_flit(4'h4, 4'hA, 8'h02), 1'b1);
    step(make_flit(4'h4, 4'hB, 8'h03), 1'b1);
    step(make_flit(4'h4, 4'hA, 8'h04), 1'b1);
    check_eq("err_after_third", 32'(bus.err_src), 32'd1);
    for (int i = 0; i < 8; i++) step(make_flit(4'h5, 4'h6, 8'(i)), 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b1);
    check_eq("err_sticky", 32'(bus.err_src), 32'd1);

    // Async reset after 2 of 4 pops
    for (int i = 0; i < 4; i++) step(make_flit(4'h7, 4'h5, 8'(8'h80 + i)), 1'b0);
    step('0, 1'b1);
    step('0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    step(make_flit(4'h8, 4'h9, 8'hAB), 1'b0);
    check_eq("post_rst_head", 32'(bus.to_x_head), 32'd1);
    step('0, 1'b1);

    // Random traffic with idle garbage (bit16 clear) and varying back-pressure
    for (int seg = 0; seg < 6; seg++) begin
      rdy_pct = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 60 : 95);
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(99) < 70) begin
          f = make_flit(4'($urandom), ($urandom_range(99) < 90) ? 4'h2 : 4'h7, 8'($urandom));
        end else begin
          f = 17'($urandom) & 17'h0FFFF;
        end
        step(f, $urandom_range(99) < rdy_pct);
      end
    end

    // Drop counter saturation on the 2-bit instance; crossbar never ready
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    for (int i = 0; i < DEPTH + 5; i++) begin
      bus2.f_a = make_flit(4'h1, 4'h1, 8'(i));
      step('0, 1'b1);
      if (i >= DEPTH) check_eq("sat_drop", 32'(bus2.drop_cnt), 32'(sat_exp[i - DEPTH]));
      else check_eq("sat_nodrop", 32'(bus2.drop_cnt), 32'd0);
    end
    bus2.f_a = '0;
    check_eq("sat_valid", 32'(bus2.to_x_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
